// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a SYNC/count/data/checksum frame, writes
// big-endian 32-bit words into instruction memory and holds the CPU in reset until a good image lands.
module imem_loader #(
  parameter int         ADDR_W = 12,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Largest image that fits in memory; a count of exactly this many words is legal.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t      state;
  state_t      state_nx;

  logic [7:0]  cnt_hi;
  logic [15:0] cnt;
  logic [15:0] hdr_cnt;
  logic [16:0] wr_cnt;
  logic [1:0]  byte_idx;
  logic [31:0] word_p0;
  logic [7:0]  csum;
  logic        accept;
  logic        is_sync;
  logic        last_word;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  assign accept    = in_valid && in_ready;
  assign is_sync   = (in_data == SYNC);
  assign hdr_cnt   = {cnt_hi, in_data};
  assign last_word = ((wr_cnt + 17'd1) == {1'b0, cnt});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (accept && is_sync) state_nx = HDR0;
      end
      HDR0: begin
        if (accept) state_nx = HDR1;
      end
      HDR1: begin
        if (accept) begin
          if ({1'b0, hdr_cnt} > MAX_WORDS) state_nx = ERR;
          else if (hdr_cnt == 16'd0)       state_nx = CSUM;
          else                             state_nx = DATA;
        end
      end
      DATA: begin
        if (accept && (byte_idx == 2'd3)) state_nx = WRITE;
      end
      WRITE: begin
        state_nx = last_word ? CSUM : DATA;
      end
      CSUM: begin
        if (accept) state_nx = (in_data == csum) ? DONE : ERR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte stage: header capture, word assembly, running checksum.
  // Write stage: outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt_hi    <= '0;
      cnt       <= '0;
      wr_cnt    <= '0;
      byte_idx  <= '0;
      word_p0   <= '0;
      csum      <= '0;
    end else begin
      in_ready <= (state_nx != WRITE);
      mem_we   <= (state_nx == WRITE);
      cpu_rst  <= (state_nx != DONE);
      done     <= (state_nx == DONE);
      err      <= (state_nx == ERR);

      if (accept) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (is_sync) begin
              cnt_hi   <= '0;
              cnt      <= '0;
              wr_cnt   <= '0;
              byte_idx <= '0;
              csum     <= '0;
              mem_addr <= '0;
            end
          end
          HDR0: begin
            cnt_hi <= in_data;
            csum   <= csum_add(csum, in_data);
          end
          HDR1: begin
            cnt  <= hdr_cnt;
            csum <= csum_add(csum, in_data);
          end
          DATA: begin
            word_p0  <= {word_p0[23:0], in_data};
            byte_idx <= byte_idx + 2'd1;
            csum     <= csum_add(csum, in_data);
            if (byte_idx == 2'd3) mem_wdata <= {word_p0[23:0], in_data};
          end
          default: ;
        endcase
      end

      // The index advances as the write cycle ends, so it stays stable during mem_we.
      if (state == WRITE) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        wr_cnt   <= wr_cnt + 17'd1;
      end
    end
  end

endmodule
